rgb2yuv_encoder: RTL and testbench



---
 rtl/rgb2yuv_encoder_if.sv | 29 ++
 rtl/rgb2yuv_encoder.sv | 203 ++++++++++++++++++++
 tb/tb_rgb2yuv_encoder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb2yuv_encoder_if.sv
// rtl/rgb2yuv_encoder_if.sv - SRAM bus and start/finish handshake for the RGB to YUV encoder
interface rgb2yuv_encoder_if;
   logic        enc_start;
   logic        enc_finish;
   logic [15:0] SRAM_read_data;
   logic [15:0] SRAM_write_data;
   logic [17:0] SRAM_address;
   logic        SRAM_we_n;

   // Encoder side: issues SRAM cycles and reports completion
   modport master (
      input  enc_start,
      input  SRAM_read_data,
      output enc_finish,
      output SRAM_write_data,
      output SRAM_address,
      output SRAM_we_n
   );

   // Top level / memory side
   modport slave (
      output enc_start,
      output SRAM_read_data,
      input  enc_finish,
      input  SRAM_write_data,
      input  SRAM_address,
      input  SRAM_we_n
   );
endinterface

// File: rtl/rgb2yuv_encoder.sv
// rtl/rgb2yuv_encoder.sv - packed RGB to planar YUV 4:2:2 encoder; CHROMA_AVG_EN selects pair-averaged chroma
module rgb2yuv_encoder #(
   parameter logic [17:0] RGB_BASE   = 18'd146944,
   parameter logic [17:0] Y_BASE     = 18'd0,
   parameter logic [17:0] U_BASE     = 18'd38400,
   parameter logic [17:0] V_BASE     = 18'd57600,
   parameter int          NUM_PIXELS = 76800
) (
   input  logic              CLOCK_50_I,
   input  logic              resetn,
   rgb2yuv_encoder_if.master bus
);

   localparam logic [17:0] LAST_G = 18'(NUM_PIXELS / 4 - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_RD5,
      S_WT0, S_WT1, S_CALC, S_WR_Y0, S_WR_Y1, S_WR_U, S_WR_V, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [17:0] g_q, g_d;
   logic [15:0] word_q [0:5];
   logic [7:0]  y_q [0:3];
   logic [7:0]  u_q [0:1];
   logic [7:0]  v_q [0:1];

   // Clamp a signed intermediate to an unsigned byte
   function automatic logic [7:0] sat8(input logic signed [19:0] v);
      if (v < 20'sd0)
         return 8'd0;
      else if (v > 20'sd255)
         return 8'd255;
      else
         return v[7:0];
   endfunction

   function automatic logic [7:0] calc_y(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      logic signed [19:0] s;
      s = 20'sd66 * $signed({12'd0, r}) + 20'sd129 * $signed({12'd0, g})
        + 20'sd25 * $signed({12'd0, b}) + 20'sd128;
      return sat8((s >>> 8) + 20'sd16);
   endfunction

   // Chroma operands are pair sums (9 bits), hence the shift by 9 instead of 8
   function automatic logic [7:0] calc_u(input logic [8:0] r, input logic [8:0] g, input logic [8:0] b);
      logic signed [19:0] s;
      s = -20'sd38 * $signed({11'd0, r}) - 20'sd74 * $signed({11'd0, g})
        + 20'sd112 * $signed({11'd0, b}) + 20'sd256;
      return sat8((s >>> 9) + 20'sd128);
   endfunction

   function automatic logic [7:0] calc_v(input logic [8:0] r, input logic [8:0] g, input logic [8:0] b);
      logic signed [19:0] s;
      s = 20'sd112 * $signed({11'd0, r}) - 20'sd94 * $signed({11'd0, g})
        - 20'sd18 * $signed({11'd0, b}) + 20'sd256;
      return sat8((s >>> 9) + 20'sd128);
   endfunction

   // Unpack the six captured words into four RGB pixels (high byte first)
   logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2, r3, g3, b3;
   assign r0 = word_q[0][15:8];
   assign g0 = word_q[0][7:0];
   assign b0 = word_q[1][15:8];
   assign r1 = word_q[1][7:0];
   assign g1 = word_q[2][15:8];
   assign b1 = word_q[2][7:0];
   assign r2 = word_q[3][15:8];
   assign g2 = word_q[3][7:0];
   assign b2 = word_q[4][15:8];
   assign r3 = word_q[4][7:0];
   assign g3 = word_q[5][15:8];
   assign b3 = word_q[5][7:0];

   logic [8:0] rs01, gs01, bs01, rs23, gs23, bs23;
`ifdef CHROMA_AVG_EN
   assign rs01 = {1'b0, r0} + {1'b0, r1};
   assign gs01 = {1'b0, g0} + {1'b0, g1};
   assign bs01 = {1'b0, b0} + {1'b0, b1};
   assign rs23 = {1'b0, r2} + {1'b0, r3};
   assign gs23 = {1'b0, g2} + {1'b0, g3};
   assign bs23 = {1'b0, b2} + {1'b0, b3};
`else
   // Decimation: the even pixel stands in for the pair, doubled to keep the same scale
   assign rs01 = {r0, 1'b0};
   assign gs01 = {g0, 1'b0};
   assign bs01 = {b0, 1'b0};
   assign rs23 = {r2, 1'b0};
   assign gs23 = {g2, 1'b0};
   assign bs23 = {b2, 1'b0};
`endif

   logic [17:0] rd_base, y_base_g, u_addr, v_addr;
   assign rd_base  = RGB_BASE + g_q * 18'd6;
   assign y_base_g = Y_BASE + {g_q[16:0], 1'b0};
   assign u_addr   = U_BASE + g_q;
   assign v_addr   = V_BASE + g_q;

   // State and group counter registers
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         g_q     <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
      end
   end

   // Capture read data two cycles after each read address, then register results in CALC
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 6; i++) word_q[i] <= '0;
         for (int i = 0; i < 4; i++) y_q[i] <= '0;
         for (int i = 0; i < 2; i++) begin
            u_q[i] <= '0;
            v_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_RD2: word_q[0] <= bus.SRAM_read_data;
            S_RD3: word_q[1] <= bus.SRAM_read_data;
            S_RD4: word_q[2] <= bus.SRAM_read_data;
            S_RD5: word_q[3] <= bus.SRAM_read_data;
            S_WT0: word_q[4] <= bus.SRAM_read_data;
            S_WT1: word_q[5] <= bus.SRAM_read_data;
            S_CALC: begin
               y_q[0] <= calc_y(r0, g0, b0);
               y_q[1] <= calc_y(r1, g1, b1);
               y_q[2] <= calc_y(r2, g2, b2);
               y_q[3] <= calc_y(r3, g3, b3);
               u_q[0] <= calc_u(rs01, gs01, bs01);
               u_q[1] <= calc_u(rs23, gs23, bs23);
               v_q[0] <= calc_v(rs01, gs01, bs01);
               v_q[1] <= calc_v(rs23, gs23, bs23);
            end
            default: ;
         endcase
      end
   end

   // Next-state logic and SRAM bus outputs decoded from the current state
   always_comb begin
      state_d             = state_q;
      g_d                 = g_q;
      bus.SRAM_address    = '0;
      bus.SRAM_write_data = '0;
      bus.SRAM_we_n       = 1'b1;
      bus.enc_finish      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.enc_start) begin
               state_d = S_RD0;
               g_d     = '0;
            end
         end
         S_RD0: begin bus.SRAM_address = rd_base;         state_d = S_RD1; end
         S_RD1: begin bus.SRAM_address = rd_base + 18'd1; state_d = S_RD2; end
         S_RD2: begin bus.SRAM_address = rd_base + 18'd2; state_d = S_RD3; end
         S_RD3: begin bus.SRAM_address = rd_base + 18'd3; state_d = S_RD4; end
         S_RD4: begin bus.SRAM_address = rd_base + 18'd4; state_d = S_RD5; end
         S_RD5: begin bus.SRAM_address = rd_base + 18'd5; state_d = S_WT0; end
         S_WT0:  state_d = S_WT1;
         S_WT1:  state_d = S_CALC;
         S_CALC: state_d = S_WR_Y0;
         S_WR_Y0: begin
            bus.SRAM_address    = y_base_g;
            bus.SRAM_write_data = {y_q[0], y_q[1]};
            bus.SRAM_we_n       = 1'b0;
            state_d             = S_WR_Y1;
         end
         S_WR_Y1: begin
            bus.SRAM_address    = y_base_g + 18'd1;
            bus.SRAM_write_data = {y_q[2], y_q[3]};
            bus.SRAM_we_n       = 1'b0;
            state_d             = S_WR_U;
         end
         S_WR_U: begin
            bus.SRAM_address    = u_addr;
            bus.SRAM_write_data = {u_q[0], u_q[1]};
            bus.SRAM_we_n       = 1'b0;
            state_d             = S_WR_V;
         end
         S_WR_V: begin
            bus.SRAM_address    = v_addr;
            bus.SRAM_write_data = {v_q[0], v_q[1]};
            bus.SRAM_we_n       = 1'b0;
            if (g_q == LAST_G) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RD0;
               g_d     = g_q + 18'd1;
            end
         end
         S_DONE: begin
            bus.enc_finish = 1'b1;
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_rgb2yuv_encoder.sv
// tb/tb_rgb2yuv_encoder.sv - scoreboard bench for rgb2yuv_encoder with a 2-cycle-latency SRAM model
module tb_rgb2yuv_encoder;
   localparam int NP = 8;
   localparam int NG = NP / 4;
   localparam int NW = 3 * NP / 2;
   localparam logic [17:0] RGB_BASE = 18'd146944;
   localparam logic [17:0] Y_BASE   = 18'd0;
   localparam logic [17:0] U_BASE   = 18'd38400;
   localparam logic [17:0] V_BASE   = 18'd57600;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   rgb2yuv_encoder_if bus();

   rgb2yuv_encoder #(
      .RGB_BASE(RGB_BASE), .Y_BASE(Y_BASE), .U_BASE(U_BASE), .V_BASE(V_BASE), .NUM_PIXELS(NP)
   ) dut (
      .CLOCK_50_I(clk),
      .resetn(resetn),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail = 0;
   int n_writes = 0;
   int n_finish = 0;

   logic [15:0] rgb_mem [0:NW-1];
   logic [15:0] rd_s1;
   logic [7:0]  pr [0:NP-1];
   logic [7:0]  pg [0:NP-1];
   logic [7:0]  pb [0:NP-1];
   logic [33:0] wr_exp [$];
   logic [17:0] rd_exp [$];

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Floor division and clamping written independently of the DUT's shift form
   function automatic int fdiv(int s, int d);
      int q;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   function automatic int sat(int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   function automatic int ref_y(int r, int g, int b);
      return sat(fdiv(66 * r + 129 * g + 25 * b + 128, 256) + 16);
   endfunction

   function automatic int ref_u(int r, int g, int b);
      return sat(fdiv(-38 * r - 74 * g + 112 * b + 256, 512) + 128);
   endfunction

   function automatic int ref_v(int r, int g, int b);
      return sat(fdiv(112 * r - 94 * g - 18 * b + 256, 512) + 128);
   endfunction

   // SRAM read path: address sampled at one edge, data presented after the next
   always @(posedge clk) begin
      if (bus.SRAM_address >= RGB_BASE && bus.SRAM_address < RGB_BASE + 18'(NW))
         rd_s1 <= rgb_mem[bus.SRAM_address - RGB_BASE];
      else
         rd_s1 <= 16'hDEAD;
      bus.SRAM_read_data <= rd_s1;
   end

   // Scoreboard: check every write and every RGB read against the expected queues
   always @(negedge clk) begin
      if (bus.SRAM_we_n === 1'b0) begin
         n_writes++;
         if (wr_exp.size() == 0) begin
            chk("spurious_write_we_n", {33'd0, bus.SRAM_we_n}, 34'd1);
         end else begin
            logic [33:0] e;
            e = wr_exp.pop_front();
            chk("wr_addr", {16'd0, bus.SRAM_address}, {16'd0, e[33:16]});
            chk("wr_data", {18'd0, bus.SRAM_write_data}, {18'd0, e[15:0]});
         end
      end else if (bus.SRAM_address >= RGB_BASE && bus.SRAM_address < RGB_BASE + 18'(NW)) begin
         if (rd_exp.size() == 0)
            chk("spurious_read", {16'd0, bus.SRAM_address}, 34'h3FFFF);
         else
            chk("rd_addr", {16'd0, bus.SRAM_address}, {16'd0, rd_exp.pop_front()});
      end
      if (bus.enc_finish === 1'b1) n_finish++;
   end

   task automatic set_all(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      for (int i = 0; i < NP; i++) begin
         pr[i] = r;
         pg[i] = g;
         pb[i] = b;
      end
   endtask

   task automatic set_ramp(input int k);
      for (int i = 0; i < NP; i++) begin
         pr[i] = 8'((i * 31 + 5 + k) % 256);
         pg[i] = 8'((250 - i * 29 + k) % 256);
         pb[i] = 8'((i * 13 + 40 + 3 * k) % 256);
      end
   endtask

   task automatic load_and_push_reads();
      for (int gi = 0; gi < NG; gi++) begin
         int p;
         p = 4 * gi;
         rgb_mem[6 * gi + 0] = {pr[p],     pg[p]};
         rgb_mem[6 * gi + 1] = {pb[p],     pr[p + 1]};
         rgb_mem[6 * gi + 2] = {pg[p + 1], pb[p + 1]};
         rgb_mem[6 * gi + 3] = {pr[p + 2], pg[p + 2]};
         rgb_mem[6 * gi + 4] = {pb[p + 2], pr[p + 3]};
         rgb_mem[6 * gi + 5] = {pg[p + 3], pb[p + 3]};
      end
      for (int i = 0; i < NW; i++) rd_exp.push_back(RGB_BASE + 18'(i));
   endtask

   task automatic push_group(input int gi, input logic [15:0] ya, input logic [15:0] yb,
                             input logic [15:0] uw, input logic [15:0] vw);
      wr_exp.push_back({Y_BASE + 18'(2 * gi), ya});
      wr_exp.push_back({Y_BASE + 18'(2 * gi + 1), yb});
      wr_exp.push_back({U_BASE + 18'(gi), uw});
      wr_exp.push_back({V_BASE + 18'(gi), vw});
   endtask

   task automatic model_group(input int gi);
      int p, ra, ga, ba, rb, gb, bb;
      int y [0:3];
      p = 4 * gi;
      for (int k = 0; k < 4; k++) y[k] = ref_y(int'(pr[p + k]), int'(pg[p + k]), int'(pb[p + k]));
`ifdef CHROMA_AVG_EN
      ra = int'(pr[p]) + int'(pr[p + 1]);     ga = int'(pg[p]) + int'(pg[p + 1]);
      ba = int'(pb[p]) + int'(pb[p + 1]);     rb = int'(pr[p + 2]) + int'(pr[p + 3]);
      gb = int'(pg[p + 2]) + int'(pg[p + 3]); bb = int'(pb[p + 2]) + int'(pb[p + 3]);
`else
      ra = 2 * int'(pr[p]);     ga = 2 * int'(pg[p]);     ba = 2 * int'(pb[p]);
      rb = 2 * int'(pr[p + 2]); gb = 2 * int'(pg[p + 2]); bb = 2 * int'(pb[p + 2]);
`endif
      push_group(gi, {8'(y[0]), 8'(y[1])}, {8'(y[2]), 8'(y[3])},
                 {8'(ref_u(ra, ga, ba)), 8'(ref_u(rb, gb, bb))},
                 {8'(ref_v(ra, ga, ba)), 8'(ref_v(rb, gb, bb))});
   endtask

   // Start a pass, optionally pulse start again mid-pass, and check finish timing and queue drain
   task automatic run_pass(input string tag, input int mid_pulse);
      int lat;
      lat = 0;
      @(posedge clk); #1;
      bus.enc_start = 1'b1;
      @(posedge clk); #1;
      for (int k = 1; k <= 13 * NG + 40; k++) begin
         @(negedge clk);
         bus.enc_start = (k == mid_pulse) ? 1'b1 : 1'b0;
         if (bus.enc_finish === 1'b1) begin
            lat = k;
            break;
         end
      end
      bus.enc_start = 1'b0;
      chk({tag, "_finish_latency"}, 34'(lat), 34'(13 * NG + 1));
      @(negedge clk);
      chk({tag, "_finish_width"}, {33'd0, bus.enc_finish}, 34'd0);
      chk({tag, "_writes_drained"}, 34'(wr_exp.size()), 34'd0);
      chk({tag, "_reads_drained"}, 34'(rd_exp.size()), 34'd0);
   endtask

   initial begin
      int wc, fc, found;
      bus.enc_start = 1'b0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_address", {16'd0, bus.SRAM_address}, 34'd0);
      chk("rst_wdata", {18'd0, bus.SRAM_write_data}, 34'd0);
      chk("rst_we_n", {33'd0, bus.SRAM_we_n}, 34'd1);
      chk("rst_finish", {33'd0, bus.enc_finish}, 34'd0);
      resetn = 1'b1;

      // All black
      set_all(8'd0, 8'd0, 8'd0);
      load_and_push_reads();
      for (int gi = 0; gi < NG; gi++) push_group(gi, 16'h1010, 16'h1010, 16'h8080, 16'h8080);
      run_pass("black", 0);

      // All white, with a start pulse in the middle of the pass
      set_all(8'd255, 8'd255, 8'd255);
      load_and_push_reads();
      for (int gi = 0; gi < NG; gi++) push_group(gi, 16'hEBEB, 16'hEBEB, 16'h8080, 16'h8080);
      run_pass("white", 8);

      // Group 0 red, group 1 blue
      for (int i = 0; i < NP; i++) begin
         pr[i] = (i < 4) ? 8'd255 : 8'd0;
         pg[i] = 8'd0;
         pb[i] = (i < 4) ? 8'd0 : 8'd255;
      end
      load_and_push_reads();
      push_group(0, 16'h5252, 16'h5252, 16'h5A5A, 16'hF0F0);
      push_group(1, 16'h2929, 16'h2929, 16'hF0F0, 16'h6E6E);
      run_pass("red_blue", 0);

      // p0 red, p1 blue, p2/p3 black in both groups
      set_all(8'd0, 8'd0, 8'd0);
      for (int gi = 0; gi < NG; gi++) begin
         pr[4 * gi] = 8'd255;
         pb[4 * gi + 1] = 8'd255;
      end
      load_and_push_reads();
      for (int gi = 0; gi < NG; gi++)
`ifdef CHROMA_AVG_EN
         push_group(gi, 16'h5229, 16'h1010, 16'hA580, 16'hAF80);
`else
         push_group(gi, 16'h5229, 16'h1010, 16'h5A80, 16'hF080);
`endif
      run_pass("mix", 0);

      // Ramp pattern against the reference model
      set_ramp(0);
      load_and_push_reads();
      for (int gi = 0; gi < NG; gi++) model_group(gi);
      run_pass("ramp", 0);

      // Reset asserted during group 1 WR_Y1
      set_ramp(7);
      load_and_push_reads();
      for (int gi = 0; gi < NG; gi++) model_group(gi);
      @(posedge clk); #1;
      bus.enc_start = 1'b1;
      @(posedge clk); #1;
      bus.enc_start = 1'b0;
      found = 0;
      for (int k = 0; k < 13 * NG + 40; k++) begin
         @(negedge clk);
         if (bus.SRAM_we_n === 1'b0 && bus.SRAM_address === Y_BASE + 18'd3) begin
            found = 1;
            break;
         end
      end
      chk("wr_y1_group1_seen", 34'(found), 34'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst_address", {16'd0, bus.SRAM_address}, 34'd0);
      chk("midrst_wdata", {18'd0, bus.SRAM_write_data}, 34'd0);
      chk("midrst_we_n", {33'd0, bus.SRAM_we_n}, 34'd1);
      chk("midrst_finish", {33'd0, bus.enc_finish}, 34'd0);
      wr_exp.delete();
      rd_exp.delete();
      wc = n_writes;
      fc = n_finish;
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_writes_after_reset", 34'(n_writes), 34'(wc));
      chk("no_finish_after_reset", 34'(n_finish), 34'(fc));

      // Restart after reset encodes again from group 0
      set_ramp(19);
      load_and_push_reads();
      for (int gi = 0; gi < NG; gi++) model_group(gi);
      run_pass("restart", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
